// File: rtl/apb_slave_mem_if.sv
// APB2-style bus bundle between the AHB-to-APB bridge and its slaves.
//
// Signals:
//   Pselx    [2:0]  slave selects, one bit per slave
//   Penable         access-phase strobe, shared by all slaves
//   Pwrite          1 = write, 0 = read
//   Paddr    [31:0] byte address
//   Pwdata   [31:0] write data
//   Prdata   [31:0] read data returned by the selected slave
//
// Modports: master (bridge side) drives the request, slave drives Prdata.
interface apb_slave_mem_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx,
        output Penable,
        output Pwrite,
        output Paddr,
        output Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx,
        input  Penable,
        input  Pwrite,
        input  Paddr,
        input  Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB2-style (no PREADY/PSLVERR) word-addressed register file used as the
// target behind the AHB-to-APB bridge. It decodes Pselx[SLV_IDX], serves
// DEPTH 32-bit words starting at BASE_ADDR, counts completed transfers and
// raises sticky flags for out-of-range accesses and APB protocol violations.
//
// Ports:
//   Pclk       APB clock, all state updates on the rising edge
//   Hresetn    asynchronous active-low reset
//   bus        apb_slave_mem_if.slave (Pselx, Penable, Pwrite, Paddr, Pwdata, Prdata)
//   wr_count   completed writes, saturating at 16'hFFFF
//   rd_count   completed reads, saturating at 16'hFFFF
//   addr_err   sticky: an out-of-range (or read-only) access completed
//   prot_err   sticky: protocol violation seen
//
// Optional feature macro: APB_SLV_RO_REGION_EN
//   Defined   -> words 0..RO_WORDS-1 are read-only; writes to them are dropped,
//                not counted, and set addr_err.
//   Undefined -> every word is writable and RO_WORDS is ignored.
module apb_slave_mem #(
    parameter int unsigned SLV_IDX   = 0,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned RO_WORDS  = 2
) (
    input  logic                  Pclk,
    input  logic                  Hresetn,
    apb_slave_mem_if.slave        bus,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic                  addr_err,
    output logic                  prot_err
);

    localparam int unsigned IdxW      = $clog2(DEPTH);
    localparam logic [31:0] SpanBytes = 32'(DEPTH * 4);
    localparam logic [31:0] BadData   = 32'hDEAD_BEEF;

    if (SLV_IDX > 2 || DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        RO_WORDS > DEPTH) begin : g_param_check
        $error("apb_slave_mem: illegal parameter combination");
    end

    // Phase of the cycle that just ended.
    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e state_q, state_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] cap_addr_q,  cap_addr_d;
    logic        cap_write_q, cap_write_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic [31:0] prdata_q,    prdata_d;
    logic [15:0] wr_count_q,  wr_count_d;
    logic [15:0] rd_count_q,  rd_count_d;
    logic        addr_err_q,  addr_err_d;
    logic        prot_err_q,  prot_err_d;

    // Live-bus decode.
    logic            sel;
    logic            setup_cyc;
    logic            access_cyc;
    logic            commit;
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;

    // Decode of the address captured at setup; the commit always uses these.
    logic [31:0]     cap_offset;
    logic            cap_in_range;
    logic [IdxW-1:0] cap_idx;
    logic            ro_hit;

    logic            mem_we;
    logic            wr_inc;
    logic            rd_inc;
    logic            addr_err_set;
    logic            req_changed;
    logic            multi_sel;
    logic            prot_err_set;

    assign sel        = bus.Pselx[SLV_IDX[1:0]];
    assign setup_cyc  = sel & ~bus.Penable;
    assign access_cyc = sel & bus.Penable;
    // Only the first access cycle after a setup completes a transfer.
    assign commit     = access_cyc & (state_q == StSetup);

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign offset   = bus.Paddr - BASE_ADDR;
    assign in_range = offset < SpanBytes;
    assign idx      = offset[2 +: IdxW];

    assign cap_offset   = cap_addr_q - BASE_ADDR;
    assign cap_in_range = cap_offset < SpanBytes;
    assign cap_idx      = cap_offset[2 +: IdxW];

`ifdef APB_SLV_RO_REGION_EN
    assign ro_hit = cap_in_range & (32'(cap_idx) < RO_WORDS);
`else
    assign ro_hit = 1'b0;
`endif

    assign mem_we       = commit & cap_write_q & cap_in_range & ~ro_hit;
    // Out-of-range writes still count; read-only hits do not.
    assign wr_inc       = commit & cap_write_q & ~ro_hit;
    assign rd_inc       = commit & ~cap_write_q;
    assign addr_err_set = commit & (~cap_in_range | (cap_write_q & ro_hit));

    assign req_changed = (bus.Paddr != cap_addr_q) |
                         (bus.Pwrite != cap_write_q) |
                         (cap_write_q & (bus.Pwdata != cap_wdata_q));

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_sel = sel & ((bus.Pselx & (bus.Pselx - 3'd1)) != 3'd0);

    assign prot_err_set = (access_cyc & (state_q != StSetup)) |
                          (commit & req_changed) |
                          multi_sel;

    always_comb begin
        state_d = StIdle;
        if (sel) begin
            state_d = bus.Penable ? StAccess : StSetup;
        end
    end

    always_comb begin
        cap_addr_d  = cap_addr_q;
        cap_write_d = cap_write_q;
        cap_wdata_d = cap_wdata_q;
        prdata_d    = prdata_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        addr_err_d  = addr_err_q | addr_err_set;
        prot_err_d  = prot_err_q | prot_err_set;

        if (setup_cyc) begin
            cap_addr_d  = bus.Paddr;
            cap_write_d = bus.Pwrite;
            cap_wdata_d = bus.Pwdata;
            // Read data is ready a cycle early so it is stable for the whole
            // access phase; writes leave the last read value on the bus.
            if (!bus.Pwrite) begin
                prdata_d = in_range ? mem_q[idx] : BadData;
            end
        end

        if (wr_inc && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (rd_inc && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge Pclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= StIdle;
            cap_addr_q  <= '0;
            cap_write_q <= 1'b0;
            cap_wdata_q <= '0;
            prdata_q    <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            addr_err_q  <= 1'b0;
            prot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_write_q <= cap_write_d;
            cap_wdata_q <= cap_wdata_d;
            prdata_q    <= prdata_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            addr_err_q  <= addr_err_d;
            prot_err_q  <= prot_err_d;
        end
    end

    always_ff @(posedge Pclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[cap_idx] <= cap_wdata_q;
        end
    end

    assign bus.Prdata = prdata_q;
    assign wr_count   = wr_count_q;
    assign rd_count   = rd_count_q;
    assign addr_err   = addr_err_q;
    assign prot_err   = prot_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
`timescale 1ns/1ps
module tb_apb_slave_mem;

    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned RO_WORDS = 2;
`ifdef APB_SLV_RO_REGION_EN
    localparam bit RoEn = 1'b1;
`else
    localparam bit RoEn = 1'b0;
`endif

    logic        Pclk = 1'b0;
    logic        Hresetn;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic        addr_err;
    logic        prot_err;

    apb_slave_mem_if bus ();

    apb_slave_mem #(
        .SLV_IDX   (0),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .RO_WORDS  (RO_WORDS)
    ) dut (
        .Pclk     (Pclk),
        .Hresetn  (Hresetn),
        .bus      (bus),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .addr_err (addr_err),
        .prot_err (prot_err)
    );

    always #5 Pclk = ~Pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int unsigned ref_wr;
    int unsigned ref_rd;
    logic        ref_aerr;
    logic        ref_perr;
    logic [31:0] exp_q [$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_wr   = 0;
        ref_rd   = 0;
        ref_aerr = 1'b0;
        ref_perr = 1'b0;
        exp_q.delete();
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Effect of one well-formed transfer, using the values presented at setup.
    function automatic void model_xfer(input logic [2:0] psel, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        bit          inr;
        int unsigned w;
        if (!psel[0]) return;
        if ($countones(psel) > 1) ref_perr = 1'b1;
        off = addr - BASE;
        inr = off < DEPTH * 4;
        w   = (off >> 2) % DEPTH;
        if (wr) begin
            if (!inr) begin
                ref_wr   = sat_inc(ref_wr);
                ref_aerr = 1'b1;
            end else if (RoEn && w < RO_WORDS) begin
                ref_aerr = 1'b1;
            end else begin
                ref_mem[w] = wdata;
                ref_wr     = sat_inc(ref_wr);
            end
        end else begin
            exp_q.push_back(inr ? ref_mem[w] : 32'hDEAD_BEEF);
            ref_rd = sat_inc(ref_rd);
            if (!inr) ref_aerr = 1'b1;
        end
    endfunction

    function automatic void check_status(input string tag);
        check({tag, ".wr_count"}, {16'h0, wr_count}, 32'(ref_wr));
        check({tag, ".rd_count"}, {16'h0, rd_count}, 32'(ref_rd));
        check({tag, ".addr_err"}, {31'h0, addr_err}, {31'h0, ref_aerr});
        check({tag, ".prot_err"}, {31'h0, prot_err}, {31'h0, ref_perr});
    endfunction

    // Monitor: every read access phase that follows a setup presents Prdata.
    bit prev_setup = 1'b0;
    always @(negedge Pclk) begin
        if (!Hresetn) begin
            prev_setup = 1'b0;
        end else begin
            if (prev_setup && bus.Pselx[0] && bus.Penable && !bus.Pwrite) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL prdata_unexpected: got %h expected no read", bus.Prdata);
                end else begin
                    check("prdata", bus.Prdata, exp_q.pop_front());
                end
            end
            prev_setup = bus.Pselx[0] && !bus.Penable;
        end
    end

    task automatic xfer(input logic [2:0] psel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bus.Pselx   = psel;
        bus.Penable = 1'b0;
        bus.Pwrite  = wr;
        bus.Paddr   = addr;
        bus.Pwdata  = wdata;
        model_xfer(psel, wr, addr, wdata);
        @(posedge Pclk); #1;
        bus.Penable = 1'b1;
        @(posedge Pclk); #1;
    endtask

    task automatic idle(input int n);
        bus.Pselx   = 3'b000;
        bus.Penable = 1'b0;
        repeat (n) begin
            @(posedge Pclk); #1;
        end
    endtask

    task automatic do_reset(input string tag);
        bus.Pselx   = 3'b000;
        bus.Penable = 1'b0;
        Hresetn     = 1'b0;
        #1;
        check({tag, ".prdata"},   bus.Prdata, 32'h0);
        check({tag, ".wr_count"}, {16'h0, wr_count}, 32'h0);
        check({tag, ".rd_count"}, {16'h0, rd_count}, 32'h0);
        check({tag, ".addr_err"}, {31'h0, addr_err}, 32'h0);
        check({tag, ".prot_err"}, {31'h0, prot_err}, 32'h0);
        model_reset();
        @(posedge Pclk); #1;
        Hresetn = 1'b1;
        idle(1);
    endtask

    task automatic read_sweep();
        for (int i = 0; i < int'(DEPTH); i++) xfer(3'b001, 1'b0, BASE + 32'(4 * i), 32'h0);
        idle(1);
    endtask

    initial begin
        logic [2:0]  psel;
        logic [31:0] addr;
        int unsigned r;

        Hresetn     = 1'b0;
        bus.Pselx   = 3'b000;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = '0;
        bus.Pwdata  = '0;
        model_reset();
        #2;
        do_reset("reset_init");

        // Write then read in range.
        xfer(3'b001, 1'b1, 32'h8000_0010, 32'hA5A5_0001);
        xfer(3'b001, 1'b0, 32'h8000_0010, 32'h0);
        idle(1);
        check_status("wr_rd");

        // Unaligned back-to-back writes, then back-to-back reads.
        xfer(3'b001, 1'b1, 32'h8000_0011, 32'h11);
        xfer(3'b001, 1'b1, 32'h8000_0022, 32'h22);
        xfer(3'b001, 1'b1, 32'h8000_0033, 32'h33);
        xfer(3'b001, 1'b0, 32'h8000_0010, 32'h0);
        xfer(3'b001, 1'b0, 32'h8000_0020, 32'h0);
        xfer(3'b001, 1'b0, 32'h8000_0030, 32'h0);
        idle(1);
        check_status("b2b");

        // Out of range above the window and below BASE.
        xfer(3'b001, 1'b0, 32'h8000_0040, 32'h0);
        idle(1);
        check_status("oor_read");
        xfer(3'b001, 1'b1, 32'h7FFF_FFFC, 32'hBAD0_0BAD);
        idle(1);
        check_status("oor_write");
        read_sweep();

        // Read-only region probe (writable unless the feature is built in).
        xfer(3'b001, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF);
        idle(1);
        check_status("ro_write");
        xfer(3'b001, 1'b1, 32'h8000_0008, 32'h0BAD_CAFE);
        xfer(3'b001, 1'b0, 32'h8000_0004, 32'h0);
        xfer(3'b001, 1'b0, 32'h8000_0008, 32'h0);
        idle(1);
        check_status("ro_after");

        // Random traffic; other slaves' selects must be ignored.
        for (int n = 0; n < 200; n++) begin
            psel = ($urandom_range(0, 9) == 0) ? 3'b010 : 3'b001;
            r    = $urandom_range(0, 15);
            if (r == 0)      addr = BASE + 32'd64 + 32'($urandom_range(0, 255));
            else if (r == 1) addr = BASE - 32'(4 * $urandom_range(1, 4));
            else             addr = BASE + 32'($urandom_range(0, 63));
            xfer(psel, 1'($urandom_range(0, 1)), addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        check_status("random");
        read_sweep();
        check_status("random_sweep");

        // Access without setup: flagged, nothing committed.
        bus.Pselx   = 3'b001;
        bus.Penable = 1'b1;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = BASE;
        bus.Pwdata  = 32'hCAFE_F00D;
        @(posedge Pclk); #1;
        ref_perr = 1'b1;
        idle(1);
        check_status("no_setup");
        xfer(3'b001, 1'b0, BASE, 32'h0);
        idle(1);

        // Reset during the access phase of a write: outputs clear at once.
        bus.Pselx   = 3'b001;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h8000_0008;
        bus.Pwdata  = 32'h1234_5678;
        @(posedge Pclk); #1;
        bus.Penable = 1'b1;
        #2;
        do_reset("reset_mid");
        xfer(3'b001, 1'b0, 32'h8000_0008, 32'h0);
        idle(1);
        check_status("post_reset");

        // Paddr changes between setup and access: flagged, lands at word 0.
        bus.Pselx   = 3'b001;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = BASE;
        bus.Pwdata  = 32'h5A5A_0000;
        model_xfer(3'b001, 1'b1, BASE, 32'h5A5A_0000);
        @(posedge Pclk); #1;
        bus.Penable = 1'b1;
        bus.Paddr   = BASE + 32'd4;
        @(posedge Pclk); #1;
        ref_perr = 1'b1;
        idle(1);
        check_status("addr_change");
        xfer(3'b001, 1'b0, BASE, 32'h0);
        xfer(3'b001, 1'b0, BASE + 32'd4, 32'h0);
        idle(1);

        // Two selects asserted at once.
        do_reset("reset_pre_multi");
        xfer(3'b001, 1'b1, 32'h8000_000C, 32'h7777_0003);
        xfer(3'b011, 1'b0, 32'h8000_000C, 32'h0);
        idle(1);
        check_status("multi_sel");

        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
